// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 configuration ROM from address 0 and issues one SCCB write per entry.
// Optional NACK retry logic is built in when OV7670_CFG_RETRY_EN is defined.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start; sccb_reg/sccb_data keep last values
//   FETCH    | rom_addr presented to the ROM
//   ROMWAIT  | ROM read latency
//   DECODE   | classify rom_dout: end marker, settle delay or register write
//   ISSUE    | wait for sccb_ready, then launch the write
//   WAITDONE | write in flight until sccb_done
//   DELAY    | settle delay count-down
//   NEXT     | advance rom_addr, or stop at the last address
//   FINISH   | one-cycle done pulse
module ov7670_config_sequencer #(
    parameter int DELAY_CYCLES = 250000,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    input  logic        sccb_ready,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_data,
    input  logic        sccb_done,
    input  logic        sccb_nack
);

    localparam int            DW         = $clog2(DELAY_CYCLES + 1);
    localparam logic [DW-1:0] DELAY_LOAD = DW'(DELAY_CYCLES - 1);
    localparam logic [15:0]   CMD_END    = 16'hFFFF;
    localparam logic [15:0]   CMD_DELAY  = 16'hFFF0;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_ROMWAIT, S_DECODE, S_ISSUE,
        S_WAITDONE, S_DELAY, S_NEXT, S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    rom_addr_q, rom_addr_d;
    logic          sccb_start_q, sccb_start_d;
    logic [7:0]    sccb_reg_q, sccb_reg_d;
    logic [7:0]    sccb_data_q, sccb_data_d;
    logic [DW-1:0] delay_q, delay_d;
    logic          error_q, error_d;

`ifdef OV7670_CFG_RETRY_EN
    localparam int            RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    logic [RW-1:0] retry_q, retry_d;
`else
    localparam int unused_max_retry = MAX_RETRY;
    logic unused_nack;
    assign unused_nack = sccb_nack;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= '0;
            sccb_start_q <= 1'b0;
            sccb_reg_q   <= '0;
            sccb_data_q  <= '0;
            delay_q      <= '0;
            error_q      <= 1'b0;
`ifdef OV7670_CFG_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            sccb_start_q <= sccb_start_d;
            sccb_reg_q   <= sccb_reg_d;
            sccb_data_q  <= sccb_data_d;
            delay_q      <= delay_d;
            error_q      <= error_d;
`ifdef OV7670_CFG_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        sccb_start_d = 1'b0;
        sccb_reg_d   = sccb_reg_q;
        sccb_data_d  = sccb_data_q;
        delay_d      = delay_q;
        error_d      = error_q;
`ifdef OV7670_CFG_RETRY_EN
        retry_d      = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rom_addr_d = '0;
                    error_d    = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH:   state_d = S_ROMWAIT;
            S_ROMWAIT: state_d = S_DECODE;
            S_DECODE: begin
`ifdef OV7670_CFG_RETRY_EN
                retry_d = '0;
`endif
                if (rom_dout == CMD_END) begin
                    state_d = S_FINISH;
                end else if (rom_dout == CMD_DELAY) begin
                    delay_d = DELAY_LOAD;
                    state_d = S_DELAY;
                end else begin
                    sccb_reg_d  = rom_dout[15:8];
                    sccb_data_d = rom_dout[7:0];
                    state_d     = S_ISSUE;
                end
            end
            // The request is registered, so it lands one cycle after ready was seen.
            S_ISSUE: begin
                if (sccb_ready) begin
                    sccb_start_d = 1'b1;
                    state_d      = S_WAITDONE;
                end
            end
            S_WAITDONE: begin
                if (sccb_done) begin
                    state_d = S_NEXT;
`ifdef OV7670_CFG_RETRY_EN
                    if (sccb_nack) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 1'b1;
                            state_d = S_ISSUE;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
`endif
                end
            end
            S_DELAY: begin
                if (delay_q == '0) begin
                    state_d = S_NEXT;
                end else begin
                    delay_d = delay_q - 1'b1;
                end
            end
            S_NEXT: begin
                if (rom_addr_q == 8'hFF) begin
                    state_d = S_FINISH;
                end else begin
                    rom_addr_d = rom_addr_q + 8'd1;
                    state_d    = S_FETCH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done       = (state_q == S_FINISH);
    assign error      = error_q;
    assign rom_addr   = rom_addr_q;
    assign sccb_start = sccb_start_q;
    assign sccb_reg   = sccb_reg_q;
    assign sccb_data  = sccb_data_q;

endmodule
